// File: rtl/class_vote_pkg.sv
// class_vote_pkg: shared helpers for the class vote accuracy unit
// Provides clog2, the per-class vote-sum width and a saturating increment.
package class_vote_pkg;

  function automatic int clog2(input int n);
    int r;
    for (r = 0; (1 << r) < n; r++) ;
    return r;
  endfunction

  // Width able to hold a vote count of 0..ch.
  function automatic int sum_w(input int ch);
    return clog2(ch + 1);
  endfunction

  // Adds one when en is set, sticking at max_v instead of wrapping.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic [63:0] max_v, input logic en);
    return (en && v != max_v) ? v + 64'd1 : v;
  endfunction

endpackage

// File: rtl/class_vote_popcount.sv
// class_vote_popcount: N-bit population count
// bits_i: vote bits of one class across all channels; count_o: number of set bits.
module class_vote_popcount #(
  parameter int N  = 7,
  parameter int SW = 3
) (
  input  logic [N-1:0]  bits_i,
  output logic [SW-1:0] count_o
);
  always_comb begin
    count_o = '0;
    for (int k = 0; k < N; k++) count_o = count_o + SW'(bits_i[k]);
  end
endmodule

// File: rtl/class_vote_accuracy_unit.sv
// class_vote_accuracy_unit: per-sample class vote argmax with running accuracy counters
// in_*: sample votes/label/sideband/last/valid; cke: global clock enable; stat_clear: restart counters.
// out_*: winning class, none/match flags and delayed sideband, 2 cke-cycles after in_*.
// stat_*: total/correct counts of a finished set, pulsed 1 cke-cycle after out_valid && out_last.
module class_vote_accuracy_unit
  import class_vote_pkg::*;
#(
  parameter int CLASS_NUM   = 10,
  parameter int CHANNEL_NUM = 7,
  parameter int USER_WIDTH  = 8,
  parameter int LABEL_WIDTH = 4,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cke,
  input  logic [CLASS_NUM*CHANNEL_NUM-1:0] in_data,
  input  logic [LABEL_WIDTH-1:0]           in_label,
  input  logic [USER_WIDTH-1:0]            in_user,
  input  logic                             in_last,
  input  logic                             in_valid,
  input  logic                             stat_clear,
  output logic [LABEL_WIDTH-1:0]           out_class,
  output logic                             out_none,
  output logic                             out_match,
  output logic [LABEL_WIDTH-1:0]           out_label,
  output logic [USER_WIDTH-1:0]            out_user,
  output logic                             out_last,
  output logic                             out_valid,
  output logic [COUNT_WIDTH-1:0]           stat_total,
  output logic [COUNT_WIDTH-1:0]           stat_ok,
  output logic                             stat_valid
);
  localparam int SW = sum_w(CHANNEL_NUM);
  localparam logic [63:0] CMAX = (64'd1 << COUNT_WIDTH) - 64'd1;
  logic [SW-1:0] sum_d [CLASS_NUM];
  logic [SW-1:0] sum_q [CLASS_NUM];
  logic [LABEL_WIDTH-1:0] s1_label_q;
  logic [USER_WIDTH-1:0] s1_user_q;
  logic s1_last_q, s1_valid_q;
  genvar i, j;
  for (i = 0; i < CLASS_NUM; i++) begin : g_cls
    logic [CHANNEL_NUM-1:0] col;
    for (j = 0; j < CHANNEL_NUM; j++) begin : g_ch
      assign col[j] = in_data[j*CLASS_NUM+i];
    end
    class_vote_popcount #(.N(CHANNEL_NUM), .SW(SW)) u_pc (.bits_i(col), .count_o(sum_d[i]));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < CLASS_NUM; k++) sum_q[k] <= '0;
      s1_label_q <= '0;
      s1_user_q  <= '0;
      s1_last_q  <= 1'b0;
      s1_valid_q <= 1'b0;
    end else if (cke) begin
      sum_q      <= sum_d;
      s1_label_q <= in_label;
      s1_user_q  <= in_user;
      s1_last_q  <= in_last;
      s1_valid_q <= in_valid;
    end
  end
  // Strict '>' while scanning upward keeps the lowest index on ties;
  // an all-zero sample never updates best_i, leaving class 0.
  logic [SW-1:0] best_v;
  logic [LABEL_WIDTH-1:0] best_i;
  logic none_d, match_d;
  always_comb begin
    best_v = '0;
    best_i = '0;
    for (int k = 0; k < CLASS_NUM; k++) begin
      if (sum_q[k] > best_v) begin
        best_v = sum_q[k];
        best_i = LABEL_WIDTH'(k);
      end
    end
    none_d  = best_v == '0;
    match_d = !none_d && best_i == s1_label_q;
  end
  logic [LABEL_WIDTH-1:0] class_q, label_q;
  logic [USER_WIDTH-1:0] user_q;
  logic none_q, match_q, last_q, valid_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      class_q <= '0;
      label_q <= '0;
      user_q  <= '0;
      none_q  <= 1'b0;
      match_q <= 1'b0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (cke) begin
      class_q <= best_i;
      label_q <= s1_label_q;
      user_q  <= s1_user_q;
      none_q  <= none_d;
      match_q <= match_d;
      last_q  <= s1_last_q;
      valid_q <= s1_valid_q;
    end
  end
  assign out_class = class_q;
  assign out_label = label_q;
  assign out_user  = user_q;
  assign out_none  = none_q;
  assign out_match = match_q;
  assign out_last  = last_q;
  assign out_valid = valid_q;
  // Counters consume the sample currently on out_*; stat_clear acts on that same cycle.
  // rep_* always include the current sample so a clear coinciding with last still reports the full set.
  logic [COUNT_WIDTH-1:0] run_total_q, run_ok_q, run_total_d, run_ok_d, rep_total, rep_ok;
  logic [COUNT_WIDTH-1:0] stat_total_q, stat_ok_q;
  logic stat_valid_q, fin;
  always_comb begin
    fin         = valid_q && last_q;
    rep_total   = COUNT_WIDTH'(sat_inc(64'(run_total_q), CMAX, valid_q));
    rep_ok      = COUNT_WIDTH'(sat_inc(64'(run_ok_q), CMAX, valid_q && match_q));
    run_total_d = fin ? '0 : stat_clear ? COUNT_WIDTH'(valid_q) : rep_total;
    run_ok_d    = fin ? '0 : stat_clear ? COUNT_WIDTH'(valid_q && match_q) : rep_ok;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      run_total_q  <= '0;
      run_ok_q     <= '0;
      stat_total_q <= '0;
      stat_ok_q    <= '0;
      stat_valid_q <= 1'b0;
    end else if (cke) begin
      run_total_q  <= run_total_d;
      run_ok_q     <= run_ok_d;
      stat_valid_q <= fin;
      if (fin) begin
        stat_total_q <= rep_total;
        stat_ok_q    <= rep_ok;
      end
    end
  end
  assign stat_total = stat_total_q;
  assign stat_ok    = stat_ok_q;
  assign stat_valid = stat_valid_q;
endmodule

// File: tb/tb_class_vote_accuracy_unit.sv
// tb_class_vote_accuracy_unit: randomized self-checking bench against a vote-counting reference model
module tb_class_vote_accuracy_unit;
  localparam int CN = 10, CH = 7, UW = 8, LW = 4, CW = 32;
  localparam longint MX = 64'hFFFF_FFFF, MX4 = 15;
  logic clk = 1'b0;
  logic reset, cke, in_last, in_valid, stat_clear;
  logic [CN*CH-1:0] in_data;
  logic [LW-1:0] in_label;
  logic [UW-1:0] in_user;
  logic [LW-1:0] out_class, out_label, s_class, s_label;
  logic [UW-1:0] out_user, s_user;
  logic out_none, out_match, out_last, out_valid, stat_valid;
  logic s_none, s_match, s_last, s_valid, s_stat_valid;
  logic [CW-1:0] stat_total, stat_ok;
  logic [3:0] s_stat_total, s_stat_ok;
  always #5 clk = ~clk;

  class_vote_accuracy_unit #(.CLASS_NUM(CN), .CHANNEL_NUM(CH), .USER_WIDTH(UW), .LABEL_WIDTH(LW), .COUNT_WIDTH(CW)) u_dut (
    .clk(clk), .reset(reset), .cke(cke), .in_data(in_data), .in_label(in_label), .in_user(in_user),
    .in_last(in_last), .in_valid(in_valid), .stat_clear(stat_clear), .out_class(out_class), .out_none(out_none),
    .out_match(out_match), .out_label(out_label), .out_user(out_user), .out_last(out_last), .out_valid(out_valid),
    .stat_total(stat_total), .stat_ok(stat_ok), .stat_valid(stat_valid));

  class_vote_accuracy_unit #(.CLASS_NUM(CN), .CHANNEL_NUM(CH), .USER_WIDTH(UW), .LABEL_WIDTH(LW), .COUNT_WIDTH(4)) u_sat (
    .clk(clk), .reset(reset), .cke(cke), .in_data(in_data), .in_label(in_label), .in_user(in_user),
    .in_last(in_last), .in_valid(in_valid), .stat_clear(stat_clear), .out_class(s_class), .out_none(s_none),
    .out_match(s_match), .out_label(s_label), .out_user(s_user), .out_last(s_last), .out_valid(s_valid),
    .stat_total(s_stat_total), .stat_ok(s_stat_ok), .stat_valid(s_stat_valid));

  typedef struct {int cls; bit none; bit match; int label; int user; bit last; bit clr; int due;} smp_t;
  typedef struct {longint tot; longint ok; longint tot4; longint ok4; int due;} st_t;
  smp_t exp_q[$];
  st_t st_q[$];
  longint m_tot, m_ok, m_tot4, m_ok4;
  int edges, n_cmp, n_bad;
  bit idle_clr, cke_rand, bub;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Count each class's votes, pick the largest count, lowest class on ties.
  function automatic void ref_eval(input logic [CN*CH-1:0] d, input int label, output int cls, output bit none, output bit match);
    int votes[CN];
    int best;
    best = 0;
    cls = 0;
    for (int c = 0; c < CN; c++) begin
      votes[c] = 0;
      for (int h = 0; h < CH; h++) votes[c] += int'(d[h*CN+c]);
      if (votes[c] > best) begin
        best = votes[c];
        cls = c;
      end
    end
    none = best == 0;
    match = !none && cls == label;
  endfunction

  function automatic longint sat(input longint v, input longint mx);
    return v < mx ? v + 1 : v;
  endfunction

  function automatic void model_zero();
    m_tot = 0; m_ok = 0; m_tot4 = 0; m_ok4 = 0;
  endfunction

  task automatic cyc();
    smp_t s;
    st_t t;
    bit pop, sv;
    longint ft, fo, ft4, fo4;
    @(negedge clk);
    if (cke) begin
      edges++;
      pop = exp_q.size() > 0 && exp_q[0].due == edges;
      check("out_valid", out_valid, pop);
      if (pop) begin
        s = exp_q.pop_front();
        check("out_class", out_class, s.cls);
        check("out_none", out_none, s.none);
        check("out_match", out_match, s.match);
        check("out_label", out_label, s.label);
        check("out_user", out_user, s.user);
        check("out_last", out_last, s.last);
        stat_clear = s.clr;
        ft = sat(m_tot, MX); fo = s.match ? sat(m_ok, MX) : m_ok;
        ft4 = sat(m_tot4, MX4); fo4 = s.match ? sat(m_ok4, MX4) : m_ok4;
        if (s.last) begin
          t = '{tot: ft, ok: fo, tot4: ft4, ok4: fo4, due: edges + 1};
          st_q.push_back(t);
          model_zero();
        end else if (s.clr) begin
          m_tot = 1; m_ok = longint'(s.match); m_tot4 = 1; m_ok4 = longint'(s.match);
        end else begin
          m_tot = ft; m_ok = fo; m_tot4 = ft4; m_ok4 = fo4;
        end
      end else begin
        stat_clear = idle_clr;
        if (idle_clr) model_zero();
        idle_clr = 0;
      end
      sv = st_q.size() > 0 && st_q[0].due == edges;
      check("stat_valid", stat_valid, sv);
      check("sat_stat_valid", s_stat_valid, sv);
      if (sv) begin
        t = st_q.pop_front();
        check("stat_total", stat_total, t.tot);
        check("stat_ok", stat_ok, t.ok);
        check("sat_stat_total", s_stat_total, t.tot4);
        check("sat_stat_ok", s_stat_ok, t.ok4);
      end
    end
    cke = cke_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    in_valid = 0;
    in_last = 0;
  endtask

  task automatic send(input logic [CN*CH-1:0] d, input int label, input bit last, input bit clr);
    smp_t s;
    forever begin
      cyc();
      if (bub && $urandom_range(0, 3) == 0) continue;
      in_data = d;
      in_label = LW'(label);
      in_user = UW'($urandom);
      in_last = last;
      in_valid = 1;
      if (cke) begin
        ref_eval(d, label, s.cls, s.none, s.match);
        s.label = label; s.user = int'(in_user); s.last = last; s.clr = clr; s.due = edges + 2;
        exp_q.push_back(s);
        break;
      end
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() > 0 || st_q.size() > 0) && k < 400) begin
      cyc();
      k++;
    end
    check("drain_pending", exp_q.size() + st_q.size(), 0);
  endtask

  // Random set of n samples, exactly nmatch of them matching unless one is forced at clr_idx.
  task automatic rand_set(input int n, input int nmatch, input bit last_end, input int clr_idx);
    logic [CN*CH-1:0] d;
    int cls, rem, label;
    bit none, m, want;
    rem = nmatch;
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < CN*CH; b++) d[b] = 1'($urandom_range(0, 1));
      ref_eval(d, 0, cls, none, m);
      want = (i == clr_idx) || ($urandom_range(1, n - i) <= rem);
      if (want && rem > 0) rem--;
      if (want && none) begin
        d[0] = 1'b1;
        cls = 0;
      end
      label = want ? cls : (cls + 1 + $urandom_range(0, 8)) % CN;
      send(d, label, last_end && i == n - 1, i == clr_idx);
    end
    drain();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; cke = 1; in_valid = 0; in_last = 0; stat_clear = 0;
    @(negedge clk);
    reset = 0;
    exp_q.delete();
    st_q.delete();
    model_zero();
    idle_clr = 0;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_class", out_class, 0);
    check("rst_out_none", out_none, 0);
    check("rst_out_match", out_match, 0);
    check("rst_out_label", out_label, 0);
    check("rst_out_user", out_user, 0);
    check("rst_out_last", out_last, 0);
    check("rst_stat_valid", stat_valid, 0);
    check("rst_stat_total", stat_total, 0);
    check("rst_stat_ok", stat_ok, 0);
    check("rst_sat_stat_total", s_stat_total, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CN*CH-1:0] d;
    reset = 1; cke = 1; in_valid = 0; in_last = 0; stat_clear = 0;
    in_data = '0; in_label = '0; in_user = '0;
    cke_rand = 0; bub = 0; idle_clr = 0; edges = 0; n_cmp = 0; n_bad = 0;
    model_zero();
    do_reset();
    d = '0;
    for (int h = 0; h < CH; h++) d[h*CN+3] = 1'b1;
    send(d, 3, 0, 0);
    d = '0;
    for (int h = 0; h < 4; h++) begin
      d[h*CN+2] = 1'b1;
      d[h*CN+5] = 1'b1;
    end
    send(d, 5, 0, 0);
    d = '0;
    send(d, 0, 1, 0);
    drain();
    check("small_set_total", stat_total, 3);
    check("small_set_ok", stat_ok, 1);
    rand_set(100, 73, 1, -1);
    check("burst_total", stat_total, 100);
    check("burst_ok", stat_ok, 73);
    check("burst_sat_total", s_stat_total, 15);
    check("burst_sat_ok", s_stat_ok, 15);
    rand_set(10, 4, 1, -1);
    check("set10_total", stat_total, 10);
    check("set10_ok", stat_ok, 4);
    cke_rand = 1; bub = 1;
    rand_set(100, 73, 1, -1);
    check("cke_burst_total", stat_total, 100);
    check("cke_burst_ok", stat_ok, 73);
    cke_rand = 0; bub = 0;
    rand_set(5, 2, 0, -1);
    idle_clr = 1;
    cyc();
    rand_set(3, 1, 1, -1);
    check("idle_clear_total", stat_total, 3);
    rand_set(60, 45, 1, 49);
    check("clear_mid_total", stat_total, 11);
    rand_set(29, 20, 0, -1);
    rand_set(2, 1, 0, -1);
    send(d, 0, 0, 0);
    do_reset();
    rand_set(5, 5, 1, -1);
    check("post_reset_total", stat_total, 5);
    rand_set(20, 20, 1, -1);
    check("sat_big_total", stat_total, 20);
    check("sat_big_ok", stat_ok, 20);
    check("sat_small_total", s_stat_total, 15);
    check("sat_small_ok", s_stat_ok, 15);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
